// File: rtl/parallel_bus_master_if.sv
// parallel_bus_master_if
// Groups the host command/response handshake and the transceiver/device-side
// bus signals of parallel_bus_master into one bundle.
//   master modport : the sequencer (drives strobes, controls, response)
//   slave  modport : the environment (host + transceiver/device side)
// Signals:
//   cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata : host command handshake
//   rsp_valid/rsp_rdata/rsp_err                   : completion pulse + data/flag
//   bus_addr/d_o/d_drv/d_i                        : device address and data path
//   bus_dir/bus_oe/bus_sel                        : transceiver controls
//   wr_n/rd_n                                     : active-low device strobes
//   bus_wait                                      : device wait request
interface parallel_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] bus_addr;
    logic [7:0] d_o;
    logic       d_drv;
    logic [7:0] d_i;
    logic       bus_dir;
    logic       bus_oe;
    logic       bus_sel;
    logic       wr_n;
    logic       rd_n;
    logic       bus_wait;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, d_i, bus_wait,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_addr, d_o, d_drv, bus_dir, bus_oe, bus_sel, wr_n, rd_n
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, d_i, bus_wait,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_addr, d_o, d_drv, bus_dir, bus_oe, bus_sel, wr_n, rd_n
    );
endinterface

// File: rtl/parallel_bus_master.sv
// parallel_bus_master
// Runs one strobed single-byte read or write on an 8-bit bidirectional bus
// through an external transceiver: SETUP -> STROBE (minimum WAIT_CYCLES,
// extended by bus_wait up to TIMEOUT extra cycles) -> HOLD -> TURN, then
// reports completion with a one-cycle rsp_valid pulse.
// Parameters:
//   WAIT_CYCLES : minimum strobe-low cycles (1..15)
//   TIMEOUT     : maximum extra strobe cycles while bus_wait=1 (1..255)
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : command/response handshake and device-side bus (master modport)
// All outputs are registered except cmd_ready, which is decoded from the state.
module parallel_bus_master #(
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    parallel_bus_master_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        TURN
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] EXT_LIMIT  = 8'(TIMEOUT);

    state_t     state_reg;
    logic       wr_reg;
    logic [3:0] count_reg;
    logic [7:0] ext_reg;

    assign bus.cmd_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wr_reg        <= 1'b0;
            count_reg     <= '0;
            ext_reg       <= '0;
            bus.wr_n      <= 1'b1;
            bus.rd_n      <= 1'b1;
            bus.bus_sel   <= 1'b0;
            bus.bus_oe    <= 1'b0;
            bus.d_drv     <= 1'b0;
            bus.bus_dir   <= 1'b0;
            bus.bus_addr  <= '0;
            bus.d_o       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            // rsp_valid is a single-cycle pulse; only the HOLD branch raises it.
            bus.rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // The address/data/direction registers double as the
                        // command latch; direction only ever changes here,
                        // while the transceiver output is still disabled.
                        wr_reg       <= bus.cmd_wr;
                        bus.bus_addr <= bus.cmd_addr;
                        bus.d_o      <= bus.cmd_wdata;
                        bus.bus_dir  <= bus.cmd_wr;
                        bus.d_drv    <= bus.cmd_wr;
                        bus.bus_sel  <= 1'b1;
                        bus.bus_oe   <= 1'b1;
                        state_reg    <= SETUP;
                    end
                end
                SETUP: begin
                    count_reg <= COUNT_LOAD;
                    ext_reg   <= '0;
                    bus.wr_n  <= ~wr_reg;
                    bus.rd_n  <= wr_reg;
                    state_reg <= STROBE;
                end
                STROBE: begin
                    if (count_reg != 4'd0) begin
                        count_reg <= count_reg - 4'd1;
                    end else if (!bus.bus_wait) begin
                        // Normal release: sample the device data on this edge.
                        bus.wr_n      <= 1'b1;
                        bus.rd_n      <= 1'b1;
                        bus.rsp_rdata <= wr_reg ? 8'h00 : bus.d_i;
                        bus.rsp_err   <= 1'b0;
                        state_reg     <= HOLD;
                    end else if (ext_reg >= EXT_LIMIT) begin
                        // Device still stalling after the full extension budget.
                        bus.wr_n      <= 1'b1;
                        bus.rd_n      <= 1'b1;
                        bus.rsp_rdata <= 8'h00;
                        bus.rsp_err   <= 1'b1;
                        state_reg     <= HOLD;
                    end else begin
                        ext_reg <= ext_reg + 8'd1;
                    end
                end
                HOLD: begin
                    // Release the transceiver; dir and addr stay put so the
                    // direction never flips while the output is enabled.
                    bus.bus_sel   <= 1'b0;
                    bus.bus_oe    <= 1'b0;
                    bus.d_drv     <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    state_reg     <= TURN;
                end
                TURN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_bus_master.sv
// tb_parallel_bus_master
// Directed bench for parallel_bus_master (WAIT_CYCLES=2, TIMEOUT=4): write,
// read, wait-extended read, timed-out read, back-to-back write/read with
// cmd_valid held, and an asynchronous reset in the middle of a write strobe.
// Outputs are sampled on the falling edge; one line is printed per transaction.
module tb_parallel_bus_master;

    localparam int W  = 2;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    parallel_bus_master_if bif();

    parallel_bus_master #(
        .WAIT_CYCLES(W),
        .TIMEOUT    (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif)
    );

    int   checks = 0;
    int   errors = 0;
    int   viol   = 0;
    logic prev_dir = 1'b0;
    logic prev_oe  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus-safety watch: no driving toward the host side, no direction flip
    // while the transceiver was enabled, no strobe/select while idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_dir <= bif.bus_dir;
            prev_oe  <= 1'b0;
        end else begin
            viol <= viol
                  + int'(bif.d_drv && !bif.bus_dir)
                  + int'((bif.bus_dir !== prev_dir) && prev_oe)
                  + int'(bif.cmd_ready && (bif.bus_sel || !bif.wr_n || !bif.rd_n));
            prev_dir <= bif.bus_dir;
            prev_oe  <= bif.bus_oe;
        end
    end

    // Issues one command at an IDLE-cycle falling edge and follows it to the
    // response. ext = number of bus_wait=1 cycles after the minimum count
    // (-1 = stuck). rdev is presented on d_i only in the releasing cycle.
    task automatic run_cmd(input string name, input logic wr, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rdev, input int ext,
                           input int exp_lat, input int exp_low, input logic [7:0] exp_rdata,
                           input logic exp_err, input logic hold);
        int         wlow = 0;
        int         rlow = 0;
        int         drv = 0;
        int         dir_bad = 0;
        int         lat = 0;
        int         given = 0;
        int         lc;
        logic [7:0] rdata = 8'h00;
        logic       err = 1'b0;
        bif.cmd_valid = 1'b1;
        bif.cmd_wr    = wr;
        bif.cmd_addr  = addr;
        bif.cmd_wdata = wdata;
        check({name, "_ready"}, 32'(bif.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) bif.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
            @(negedge clk);
            if (!bif.wr_n) wlow++;
            if (!bif.rd_n) rlow++;
            if (bif.d_drv) drv++;
            if (bif.bus_sel && (bif.bus_dir !== wr)) dir_bad++;
            if (bif.rsp_valid) begin
                lat   = cyc;
                rdata = bif.rsp_rdata;
                err   = bif.rsp_err;
            end
            if (!bif.wr_n || !bif.rd_n) begin
                lc = wlow + rlow;
                if (lc == 1) begin
                    check({name, "_addr"}, 32'(bif.bus_addr), 32'(addr));
                    if (wr) check({name, "_dout"}, 32'(bif.d_o), 32'(wdata));
                end
                if (lc < W) begin
                    bif.bus_wait = (ext != 0);
                    bif.d_i      = 8'hFF;
                end else if (ext < 0 || given < ext) begin
                    bif.bus_wait = 1'b1;
                    given++;
                    bif.d_i      = 8'hFF;
                end else begin
                    bif.bus_wait = 1'b0;
                    bif.d_i      = rdev;
                end
            end else begin
                bif.bus_wait = (ext != 0);
                bif.d_i      = 8'hFF;
            end
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_wr_low"}, 32'(wlow), wr ? 32'(exp_low) : 32'd0);
        check({name, "_rd_low"}, 32'(rlow), wr ? 32'd0 : 32'(exp_low));
        check({name, "_drv"}, 32'(drv), wr ? 32'(exp_low + 2) : 32'd0);
        check({name, "_dir"}, 32'(dir_bad), 32'd0);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        if (!wr) check({name, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        @(negedge clk);
        bif.bus_wait = 1'b0;
        check({name, "_pulse"}, 32'(bif.rsp_valid), 32'd0);
        check({name, "_idle"}, 32'(bif.cmd_ready), 32'd1);
        $display("txn %s: wr=%0b addr=0x%02h lat=%0d wr_low=%0d rd_low=%0d rdata=0x%02h err=%0b",
                 name, wr, addr, lat, wlow, rlow, rdata, err);
    endtask

    int rsp_seen;
    int not_ready;

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_wr    = 1'b0;
        bif.cmd_addr  = 8'h00;
        bif.cmd_wdata = 8'h00;
        bif.d_i       = 8'hFF;
        bif.bus_wait  = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #6;
        check("rst_strobes", 32'({bif.wr_n, bif.rd_n}), 32'h3);
        check("rst_ctrl", 32'({bif.bus_sel, bif.bus_oe, bif.d_drv, bif.bus_dir,
                               bif.rsp_valid, bif.rsp_err}), 32'h0);
        check("rst_addr", 32'(bif.bus_addr), 32'h0);
        check("rst_data", 32'({bif.d_o, bif.rsp_rdata}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bif.cmd_ready), 32'd1);

        //      name       wr    addr   wdata  rdev   ext lat low rdata  err  hold
        run_cmd("wr_a5",   1'b1, 8'h3C, 8'hA5, 8'h00, 0,  5,  2,  8'h00, 1'b0, 1'b0);
        run_cmd("rd_5a",   1'b0, 8'h10, 8'h00, 8'h5A, 0,  5,  2,  8'h5A, 1'b0, 1'b0);
        run_cmd("rd_wait", 1'b0, 8'h22, 8'h00, 8'hC3, 3,  8,  5,  8'hC3, 1'b0, 1'b0);
        run_cmd("rd_tmo",  1'b0, 8'h44, 8'h00, 8'h77, -1, 9,  6,  8'h00, 1'b1, 1'b0);
        run_cmd("b2b_wr",  1'b1, 8'h81, 8'h5E, 8'h00, 0,  5,  2,  8'h00, 1'b0, 1'b1);
        run_cmd("b2b_rd",  1'b0, 8'h81, 8'h00, 8'h96, 0,  5,  2,  8'h96, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a write strobe.
        bif.cmd_valid = 1'b1;
        bif.cmd_wr    = 1'b1;
        bif.cmd_addr  = 8'h77;
        bif.cmd_wdata = 8'h33;
        @(posedge clk);
        #1 bif.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_strobe", 32'(bif.wr_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_n", 32'(bif.wr_n), 32'd1);
        check("mid_rst_ctrl", 32'({bif.d_drv, bif.bus_oe, bif.bus_sel, bif.rsp_valid}), 32'h0);
        check("mid_rst_ready", 32'(bif.cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        rsp_seen  = 0;
        not_ready = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bif.rsp_valid) rsp_seen++;
            if (!bif.cmd_ready) not_ready++;
        end
        check("mid_rst_no_rsp", 32'(rsp_seen), 32'd0);
        check("mid_rst_ready_after", 32'(not_ready), 32'd0);
        $display("txn mid_rst: rsp_seen=%0d not_ready=%0d", rsp_seen, not_ready);

        check("invariants", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_bus_master.md
# parallel_bus_master

Sequencing stage that drives the 8-bit bidirectional bus transceiver and its OE/DIR/select controls. It accepts single-byte read/write commands from the internal host, runs a strobed bus cycle with programmable wait states, device-driven wait extension and timeout, and returns read data. It sits directly upstream of the transceiver: its data, direction, output-enable and select outputs feed the transceiver's device-side data bus, DIR, OE and select inputs.

## Interface
- WAIT_CYCLES, 2: minimum strobe-low cycles, legal range 1..15
- TIMEOUT, 255: maximum extra strobe cycles allowed while bus_wait=1, legal range 1..255
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  8  device address
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- bus_addr  out  8  address to device
- d_o  out  8  write data toward the transceiver
- d_drv  out  1  tristate enable for d_o (1 = drive)
- d_i  in  8  data returned through the transceiver
- bus_dir  out  1  transceiver direction, 1 = toward device (write)
- bus_oe  out  1  transceiver output enable, active high
- bus_sel  out  1  transceiver select
- wr_n, rd_n  out  1 each  device strobes, active low
- bus_wait  in  1  device wait request, synchronous to clk

## Operation
- States: IDLE, SETUP, STROBE, HOLD, TURN. cmd_ready = (state == IDLE).
- IDLE: bus_sel=0, bus_oe=0, d_drv=0, strobes high. Accept → latch cmd_wr, cmd_addr and cmd_wdata → SETUP.
- SETUP (1 cycle): bus_addr=addr, bus_dir=wr, bus_sel=1, bus_oe=1, d_drv=wr, d_o=wdata.
- STROBE: wr_n=0 for a write, rd_n=0 for a read. Counter loads WAIT_CYCLES-1 and decrements each cycle. At count 0:
  - bus_wait=0 → HOLD.
  - bus_wait=1 → extend. Extension counter increments each cycle bus_wait=1.
  - Extension counter reaching TIMEOUT with bus_wait still 1 → set err, HOLD.
- Read capture: d_i registered on the clock edge that leaves STROBE without timeout. On timeout, rdata=0x00.
- HOLD (1 cycle): strobes high; addr, dir, sel, oe and data held.
- TURN (1 cycle): bus_sel=0, bus_oe=0, d_drv=0; bus_dir and bus_addr held. rsp_valid=1 with rdata and err. Next state is IDLE.
- bus_dir changes only in IDLE→SETUP, i.e. while bus_oe=0. d_drv=1 never coincides with bus_dir=0.
- Counters use saturating compare with no wrap. The extension counter is 8 bits.

## Timing
- Reset (asynchronous, immediate, including mid-cycle) sets state=IDLE, all strobes=1, bus_sel=0, bus_oe=0, d_drv=0, bus_dir=0, bus_addr=0, d_o=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- cmd_ready=1 in the first cycle after rst_n deasserts.
- All outputs are registered except cmd_ready.
- Latency from the accept edge to rsp_valid = 1 + WAIT_CYCLES + ext + 2 cycles. With WAIT_CYCLES=2 and no wait, rsp_valid is high in the 5th cycle after accept.
- cmd_valid during a busy cycle is ignored, and cmd_ready=0. The next command is accepted in the cycle after TURN, which gives back-to-back throughput of one command per WAIT_CYCLES+4 cycles.
- bus_wait is ignored outside STROBE and before the minimum count expires.

## Test plan
- Write 0xA5 to addr 0x3C, WAIT_CYCLES=2, bus_wait=0 → wr_n low exactly 2 cycles; d_drv=1 and bus_dir=1 from SETUP through HOLD; rsp_valid in cycle 5, err=0.
- Read addr 0x10, device presents 0x5A on d_i → rd_n low 2 cycles, d_drv=0, bus_dir=0; rsp_rdata=0x5A, err=0.
- Read with bus_wait=1 for 3 cycles after the minimum count → rd_n low 5 cycles; rsp_valid in cycle 8; data captured at the release edge.
- Read with bus_wait stuck at 1, TIMEOUT=4 → rd_n low 2+4 cycles; rsp_err=1, rsp_rdata=0x00; return to IDLE.
- Write then read back-to-back with cmd_valid held high → second accept in the cycle after TURN; bus_oe=0 whenever bus_dir toggles; d_drv never 1 with bus_dir=0.
- Assert rst_n=0 during STROBE of a write → wr_n, d_drv, bus_oe and bus_sel go inactive immediately; no rsp_valid; cmd_ready=1 after release.
